// File: rtl/exe_result_fifo_if.sv
// Result-queue bus: upstream push handshake, writeback pop handshake and status.
// The slave modport is the queue itself; master is the surrounding logic.
interface exe_result_fifo_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
);
   logic                     i_valid;
   logic                     o_ready;
   logic [3:0]               i_oper;
   logic [WIDTH-1:0]         i_result;
   logic                     i_error;
   logic                     i_carry;
   logic                     o_valid;
   logic                     i_ready;
   logic [3:0]               o_oper;
   logic [WIDTH-1:0]         o_result;
   logic                     o_error;
   logic                     o_carry;
   logic [$clog2(DEPTH):0]   o_count;
   logic                     o_sticky_error;
   logic                     o_sticky_carry;
   logic                     i_clr_sticky;
   logic [CNT_W-1:0]         o_err_cnt;

   modport slave (
      input  i_valid, i_oper, i_result, i_error, i_carry, i_ready, i_clr_sticky,
      output o_ready, o_valid, o_oper, o_result, o_error, o_carry, o_count,
             o_sticky_error, o_sticky_carry, o_err_cnt
   );

   modport master (
      output i_valid, i_oper, i_result, i_error, i_carry, i_ready, i_clr_sticky,
      input  o_ready, o_valid, o_oper, o_result, o_error, o_carry, o_count,
             o_sticky_error, o_sticky_carry, o_err_cnt
   );
endinterface

// File: rtl/exe_result_fifo.sv
// FWFT result queue with sticky error/carry and saturating error count; 1-cycle push-to-head latency.
// Backpressure: o_ready drops only when full (from registered count); i_ready never bypasses a full queue.
module exe_result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rsn,
   exe_result_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [3:0]       oper;
      logic [WIDTH-1:0] result;
      logic             error;
      logic             carry;
   } entry_t;

   entry_t            mem [DEPTH];
   entry_t            head;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              sticky_error;
   logic              sticky_carry;
   logic [CNT_W-1:0]  err_cnt;
   logic              push;
   logic              pop;
   logic              push_err;
   logic              push_carry;

   assign bus.o_ready = !i_rsn && (count < CW'(DEPTH));
   assign bus.o_valid = !i_rsn && (count != '0);
   assign push        = bus.i_valid && bus.o_ready;
   assign pop         = bus.o_valid && bus.i_ready;
   assign push_err    = push && bus.i_error;
   assign push_carry  = push && bus.i_carry;

   // Head fields are forced to zero whenever nothing is queued.
   assign head         = mem[rd_ptr];
   assign bus.o_oper   = bus.o_valid ? head.oper   : '0;
   assign bus.o_result = bus.o_valid ? head.result : '0;
   assign bus.o_error  = bus.o_valid ? head.error  : 1'b0;
   assign bus.o_carry  = bus.o_valid ? head.carry  : 1'b0;

   assign bus.o_count        = count;
   assign bus.o_sticky_error = sticky_error;
   assign bus.o_sticky_carry = sticky_carry;
   assign bus.o_err_cnt      = err_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rsn) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         sticky_error <= 1'b0;
         sticky_carry <= 1'b0;
         err_cnt      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{oper: bus.i_oper, result: bus.i_result,
                             error: bus.i_error, carry: bus.i_carry};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // A same-edge flagged push takes priority over the clear.
         if (push_err)               sticky_error <= 1'b1;
         else if (bus.i_clr_sticky)  sticky_error <= 1'b0;
         if (push_carry)             sticky_carry <= 1'b1;
         else if (bus.i_clr_sticky)  sticky_carry <= 1'b0;

         if (bus.i_clr_sticky)
            err_cnt <= push_err ? CNT_W'(1) : '0;
         else if (push_err && (err_cnt != {CNT_W{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_exe_result_fifo.sv
// Directed bench for exe_result_fifo with a queue scoreboard and a reference occupancy/status model.
module tb_exe_result_fifo;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   typedef struct packed {
      logic [3:0]  oper;
      logic [31:0] result;
      logic        error;
      logic        carry;
   } ent_t;

   logic clk;
   logic rsn;
   int   checks;
   int   failures;
   int   mcount;
   int   mcnt;
   logic msticky_err;
   logic msticky_car;
   int   npush;
   ent_t sb[$];

   exe_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   exe_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .i_clk (clk),
      .i_rsn (rsn),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the model, advance the model, then cross the edge.
   task automatic cycle();
      logic exp_rdy;
      logic exp_vld;
      logic do_push;
      logic do_pop;
      ent_t e;
      exp_rdy = !rsn && (mcount < DEPTH);
      exp_vld = !rsn && (mcount != 0);
      chk("o_ready", bus.o_ready, exp_rdy);
      chk("o_valid", bus.o_valid, exp_vld);
      chk("o_count", bus.o_count, mcount);
      chk("o_sticky_error", bus.o_sticky_error, msticky_err);
      chk("o_sticky_carry", bus.o_sticky_carry, msticky_car);
      chk("o_err_cnt", bus.o_err_cnt, mcnt);
      if (exp_vld) begin
         e = sb[0];
         chk("head_oper", bus.o_oper, e.oper);
         chk("head_result", bus.o_result, e.result);
         chk("head_error", bus.o_error, e.error);
         chk("head_carry", bus.o_carry, e.carry);
      end else begin
         chk("idle_data", {bus.o_oper, bus.o_result, bus.o_error, bus.o_carry}, 64'd0);
      end
      do_push = bus.i_valid && exp_rdy;
      do_pop  = exp_vld && bus.i_ready;
      if (!rsn) begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) begin
            sb.push_back('{oper: bus.i_oper, result: bus.i_result,
                           error: bus.i_error, carry: bus.i_carry});
            npush++;
         end
         mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
         if (do_push && bus.i_error)  msticky_err = 1'b1;
         else if (bus.i_clr_sticky)   msticky_err = 1'b0;
         if (do_push && bus.i_carry)  msticky_car = 1'b1;
         else if (bus.i_clr_sticky)   msticky_car = 1'b0;
         if (bus.i_clr_sticky)             mcnt = (do_push && bus.i_error) ? 1 : 0;
         else if (do_push && bus.i_error)  mcnt = (mcnt == 255) ? 255 : mcnt + 1;
      end
      @(posedge clk);
      #1;
      if (rsn) begin
         sb.delete();
         mcount      = 0;
         mcnt        = 0;
         msticky_err = 1'b0;
         msticky_car = 1'b0;
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] res,
                        input logic er, input logic ca);
      bus.i_valid  = v;
      bus.i_oper   = op;
      bus.i_result = res;
      bus.i_error  = er;
      bus.i_carry  = ca;
   endtask

   task automatic drain();
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      for (int k = 0; k < 8 && mcount != 0; k++) cycle();
      chk("drain_empty", bus.o_count, 0);
   endtask

   initial begin
      checks = 0; failures = 0; mcount = 0; mcnt = 0; npush = 0;
      msticky_err = 1'b0; msticky_car = 1'b0;
      rsn = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      bus.i_ready = 1'b0;
      bus.i_clr_sticky = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_o_valid", bus.o_valid, 0);
      chk("rst_o_ready", bus.o_ready, 0);
      chk("rst_o_count", bus.o_count, 0);
      chk("rst_err_cnt", bus.o_err_cnt, 0);
      chk("rst_sticky", {bus.o_sticky_error, bus.o_sticky_carry}, 0);
      rsn = 1'b0;
      #1;
      chk("post_rst_ready", bus.o_ready, 1);

      // Single push, visible one cycle later
      drive(1'b1, 4'd0, 32'h0000_0005, 1'b0, 1'b1);
      cycle();
      drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      chk("t1_valid", bus.o_valid, 1);
      chk("t1_result", bus.o_result, 5);
      chk("t1_carry", bus.o_carry, 1);
      chk("t1_count", bus.o_count, 1);
      chk("t1_sticky_carry", bus.o_sticky_carry, 1);
      drain();
      bus.i_ready = 1'b0;

      // Fill to full, hold a 5th, then drain in order
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 4'(k), 32'(k), 1'b0, 1'b0);
         cycle();
      end
      chk("full_count", bus.o_count, 4);
      chk("full_ready", bus.o_ready, 0);
      drive(1'b1, 4'd5, 32'd5, 1'b0, 1'b0);
      cycle();
      cycle();
      chk("full_hold_count", bus.o_count, 4);
      drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      bus.i_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("order_result", bus.o_result, k);
         cycle();
      end
      chk("empty_valid", bus.o_valid, 0);
      chk("empty_data", {bus.o_oper, bus.o_result, bus.o_error, bus.o_carry}, 0);

      // Steady push+pop at occupancy 2 across pointer wrap
      bus.i_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 4'hA, 32'hA0 + 32'(k), 1'b0, 1'b0);
         cycle();
      end
      bus.i_ready = 1'b1;
      for (int k = 2; k < 12; k++) begin
         chk("stream_result", bus.o_result, 32'hA0 + 32'(k - 2));
         drive(1'b1, 4'(k), 32'hA0 + 32'(k), 1'b0, 1'($urandom_range(0, 1)));
         cycle();
         chk("stream_count", bus.o_count, 2);
      end
      drain();

      // Error counter saturation
      npush = 0;
      for (int k = 0; k < 400 && npush < 300; k++) begin
         drive(1'b1, 4'(k), 32'(k * 3), 1'b1, 1'($urandom_range(0, 1)));
         cycle();
      end
      chk("push300_total", npush, 300);
      drain();
      chk("sat_err_cnt", bus.o_err_cnt, 255);
      chk("sat_sticky_err", bus.o_sticky_error, 1);
      bus.i_clr_sticky = 1'b1;
      drive(1'b1, 4'd7, 32'h77, 1'b1, 1'b0);
      cycle();
      drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      chk("clr_push_err_cnt", bus.o_err_cnt, 1);
      chk("clr_push_sticky", bus.o_sticky_error, 1);
      cycle();
      bus.i_clr_sticky = 1'b0;
      chk("clr_err_cnt", bus.o_err_cnt, 0);
      chk("clr_sticky", {bus.o_sticky_error, bus.o_sticky_carry}, 0);
      drain();

      // Mid-operation reset discards entries and the pending push
      bus.i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 4'hC, 32'hC0 + 32'(k), 1'b1, 1'b1);
         cycle();
      end
      chk("pre_rst_count", bus.o_count, 3);
      rsn = 1'b1;
      drive(1'b1, 4'hD, 32'hDEAD, 1'b1, 1'b1);
      #1;
      chk("in_rst_ready", bus.o_ready, 0);
      chk("in_rst_valid", bus.o_valid, 0);
      cycle();
      chk("mid_rst_count", bus.o_count, 0);
      chk("mid_rst_err_cnt", bus.o_err_cnt, 0);
      chk("mid_rst_sticky", {bus.o_sticky_error, bus.o_sticky_carry}, 0);
      rsn = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      bus.i_ready = 1'b1;
      #1;
      chk("after_rst_ready", bus.o_ready, 1);
      chk("after_rst_valid", bus.o_valid, 0);
      cycle();
      cycle();
      chk("after_rst_count", bus.o_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
